// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART receiver, the transmitter and the
// command assembler.
//   state_t         : command assembler FSM states (IDLE, WAIT_LO)
//   CLK_FREQ, BAUD  : system clock and line rate
//   BIT_CYC         : clk cycles per UART bit
//   HALF_BIT_CYC    : clk cycles to the middle of a bit (receiver sampling)
//   TIMEOUT_CYC_DEF : inter-byte timeout, about 2.5 byte-times at BAUD
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD            = 9600;
  localparam int BIT_CYC         = 5208;
  localparam int HALF_BIT_CYC    = 2604;
  localparam int TIMEOUT_CYC_DEF = 130208;

endpackage

// File: rtl/cmd_timeout_tmr.sv
// ---------------------------------------------------------------------------
// cmd_timeout_tmr
// Inter-byte timer for the command assembler. Counts enabled cycles from a
// clear and raises expired once TIMEOUT_CYC-1 is reached. The count saturates
// at that value, so it never wraps back into a "fresh" window.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0)
//   en      : count this cycle
//   expired : count == TIMEOUT_CYC-1 (combinational from the count)
// ---------------------------------------------------------------------------
module cmd_timeout_tmr #(
  parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC_DEF,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_reg;

  assign expired = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en && !expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// uart_cmd_assembler
// Packs two consecutive UART bytes (high byte first) into a 16-bit command.
// Owns the receiver's ready-clear so each byte is consumed exactly once.
// A high byte left waiting longer than TIMEOUT_CYC cycles is dropped so the
// byte framing recovers on its own.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_rdy       : receiver byte valid (level until cleared)
//   rx_data      : received byte
//   clr_rx_rdy   : combinational accept pulse back to the receiver
//   cmd          : last completed command {hi, lo}
//   cmd_rdy      : command valid, held until clr_cmd_rdy
//   clr_cmd_rdy  : consumer acknowledge
//   timeout      : one-cycle pulse, stranded high byte discarded
//   overrun      : one-cycle pulse, unacknowledged command overwritten
// ---------------------------------------------------------------------------
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout,
  output logic        overrun
);

  state_t      state_reg, state_next;
  logic [7:0]  hi_reg, hi_next;
  logic [15:0] cmd_reg, cmd_next;
  logic        cmd_rdy_reg, cmd_rdy_next;
  logic        timeout_reg, timeout_next;
  logic        overrun_reg, overrun_next;
  logic        rx_accept;
  logic        tmr_clr, tmr_en, tmr_expired;

  cmd_timeout_tmr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      hi_reg      <= 8'h00;
      cmd_reg     <= 16'h0000;
      cmd_rdy_reg <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hi_reg      <= hi_next;
      cmd_reg     <= cmd_next;
      cmd_rdy_reg <= cmd_rdy_next;
      timeout_reg <= timeout_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    cmd_next     = cmd_reg;
    // Acknowledge clears a pending command; a completion below overrides it.
    cmd_rdy_next = cmd_rdy_reg & ~clr_cmd_rdy;
    timeout_next = 1'b0;
    overrun_next = 1'b0;
    rx_accept    = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    case (state_reg)
      IDLE: begin
        // Hold the timer at zero so WAIT_LO always starts a fresh window.
        tmr_clr = 1'b1;
        if (rx_rdy) begin
          rx_accept  = 1'b1;
          hi_next    = rx_data;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the expiry cycle still completes the pair.
        if (rx_rdy) begin
          rx_accept    = 1'b1;
          cmd_next     = {hi_reg, rx_data};
          cmd_rdy_next = 1'b1;
          overrun_next = cmd_rdy_reg & ~clr_cmd_rdy;
          state_next   = IDLE;
        end else if (tmr_expired) begin
          timeout_next = 1'b1;
          hi_next      = 8'h00;
          state_next   = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign clr_rx_rdy = rx_accept & ~rst;
  assign cmd        = cmd_reg;
  assign cmd_rdy    = cmd_rdy_reg;
  assign timeout    = timeout_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_assembler
// Directed scenarios plus a randomized byte stream, checked against a
// behavioural model of the byte-pairing rules (pending high byte with an
// age, completed command, ready flag, pulse flags).
// ---------------------------------------------------------------------------
module tb_uart_cmd_assembler;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        timeout;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse counters sampled on the active edge (values from the previous cycle).
  int clr_cnt = 0;
  int to_cnt  = 0;
  int ov_cnt  = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    clr_cnt += int'(clr_rx_rdy);
    to_cnt  += int'(timeout);
    ov_cnt  += int'(overrun);
  end

  // Reference model: a byte is either waiting as the high half (with its age
  // in cycles) or not; pairs become commands, stale high bytes are dropped.
  logic        m_pending = 1'b0;
  logic [7:0]  m_hi      = 8'h00;
  int          m_age     = 0;
  logic [15:0] m_cmd     = 16'h0000;
  logic        m_rdy     = 1'b0;
  logic        m_to      = 1'b0;
  logic        m_ov      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pending = 1'b0; m_hi = 8'h00; m_age = 0;
      m_cmd = 16'h0000; m_rdy = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    end else begin
      m_to = 1'b0;
      m_ov = 1'b0;
      if (m_pending && rx_rdy) begin
        m_ov      = m_rdy && !clr_cmd_rdy;
        m_cmd     = {m_hi, rx_data};
        m_rdy     = 1'b1;
        m_pending = 1'b0;
      end else begin
        if (clr_cmd_rdy) m_rdy = 1'b0;
        if (m_pending) begin
          if (m_age >= TO - 1) begin
            m_pending = 1'b0;
            m_to      = 1'b1;
          end else begin
            m_age++;
          end
        end else if (rx_rdy) begin
          m_pending = 1'b1;
          m_hi      = rx_data;
          m_age     = 0;
        end
      end
    end
  end

  // Present a byte for one cycle (the receiver drops rdy after the accept
  // edge). Returns at the falling edge just after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic ack_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd !== 16'h0000) begin n_err++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_cmp++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    n_cmp++;
    if (clr_rx_rdy !== 1'b0) begin n_err++; $display("FAIL reset_clr_rx_rdy: got %b want 0", clr_rx_rdy); end
    n_cmp++;
    if (timeout !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: got to=%b ov=%b want 0 0", timeout, overrun);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int c0;
    c0 = clr_cnt;
    send_byte(8'hA5);
    repeat (19) @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = 8'h3C;
    #1;
    n_cmp++;
    if (clr_rx_rdy !== 1'b1) begin n_err++; $display("FAIL basic_clr_comb: got %b want 1", clr_rx_rdy); end
    n_cmp++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL basic_early_rdy: got %b want 0", cmd_rdy); end
    @(negedge clk);
    rx_rdy = 1'b0;
    n_cmp++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL basic_cmd: got %h/%b want a53c/1", cmd, cmd_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (clr_cnt - c0 !== 2) begin n_err++; $display("FAIL basic_clr_count: got %0d want 2", clr_cnt - c0); end
    $display("test_basic cmd=%h", cmd);
  endtask

  task automatic test_ack();
    ack_cmd();
    n_cmp++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_err++; $display("FAIL ack_clear: got %h/%b want a53c/0", cmd, cmd_rdy);
    end
    ack_cmd();
    n_cmp++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_err++; $display("FAIL ack_idle: got %h/%b want a53c/0", cmd, cmd_rdy);
    end
    $display("test_ack cmd_rdy=%b", cmd_rdy);
  endtask

  task automatic test_timeout();
    int t0;
    int width;
    t0 = to_cnt;
    width = 0;
    send_byte(8'h12);
    for (int i = 0; i < 105; i++) begin
      @(negedge clk);
      width += int'(timeout);
      n_cmp++;
      if (timeout !== m_to) begin n_err++; $display("FAIL timeout_cycle%0d: got %b want %b", i, timeout, m_to); end
    end
    n_cmp++;
    if (to_cnt - t0 !== 1 || width !== 1) begin
      n_err++; $display("FAIL timeout_pulse: got count %0d width %0d want 1 1", to_cnt - t0, width);
    end
    n_cmp++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_err++; $display("FAIL timeout_cmd_hold: got %h/%b want a53c/0", cmd, cmd_rdy);
    end
    send_byte(8'h34);
    send_byte(8'h56);
    n_cmp++;
    if (cmd !== 16'h3456 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL timeout_recover: got %h/%b want 3456/1", cmd, cmd_rdy);
    end
    $display("test_timeout cmd=%h", cmd);
  endtask

  task automatic test_race();
    int t0;
    ack_cmd();
    t0 = to_cnt;
    send_byte(8'h11);
    // The low byte is sampled on the 100th edge after the high byte's accept,
    // i.e. the cycle the waiting count reaches TO-1.
    repeat (98) @(negedge clk);
    send_byte(8'h77);
    n_cmp++;
    if (cmd !== 16'h1177 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL race_cmd: got %h/%b want 1177/1", cmd, cmd_rdy);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (to_cnt !== t0) begin n_err++; $display("FAIL race_timeout: got %0d pulses want 0", to_cnt - t0); end
    $display("test_race cmd=%h", cmd);
  endtask

  task automatic test_overrun();
    int o0;
    ack_cmd();
    o0 = ov_cnt;
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'hCA);
    send_byte(8'hFE);
    n_cmp++;
    if (overrun !== 1'b1 || cmd !== 16'hCAFE || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got ov=%b %h/%b want 1 cafe/1", overrun, cmd, cmd_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0 || ov_cnt - o0 !== 1) begin
      n_err++; $display("FAIL overrun_width: got ov=%b count %0d want 0 1", overrun, ov_cnt - o0);
    end
    send_byte(8'h12);
    @(negedge clk);
    rx_rdy      = 1'b1;
    rx_data     = 8'h34;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL overrun_ack_race: got ov=%b %h/%b want 0 1234/1", overrun, cmd, cmd_rdy);
    end
    $display("test_overrun cmd=%h", cmd);
  endtask

  task automatic test_mid_reset();
    send_byte(8'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: got %h/%b want 0000/0", cmd, cmd_rdy);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    n_cmp++;
    if (cmd !== 16'h0102 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL midrst_cmd: got %h/%b want 0102/1", cmd, cmd_rdy);
    end
    $display("test_mid_reset cmd=%h", cmd);
  endtask

  task automatic test_random();
    int gap;
    int ncmd;
    gap  = 0;
    ncmd = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cmd !== m_cmd || cmd_rdy !== m_rdy || timeout !== m_to || overrun !== m_ov) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h/%b to=%b ov=%b want %h/%b to=%b ov=%b",
                 i, cmd, cmd_rdy, timeout, overrun, m_cmd, m_rdy, m_to, m_ov);
      end
      ncmd += int'(cmd_rdy && !m_pending && overrun);
      // Receiver drops rdy right after the accept edge.
      if (rx_rdy) begin
        rx_rdy = 1'b0;
      end else if (gap == 0) begin
        rx_rdy  = 1'b1;
        rx_data = 8'($urandom);
        gap     = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 5, TO + 5)
                                               : $urandom_range(0, 6);
      end else begin
        gap--;
      end
      clr_cmd_rdy = ($urandom_range(0, 3) == 0);
    end
    clr_cmd_rdy = 1'b0;
    rx_rdy      = 1'b0;
    $display("test_random done, overrun completions seen=%0d", ncmd);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack();
    test_timeout();
    test_race();
    test_overrun();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Consumes bytes from the UART receiver (rx_data/rdy/clr_rdy handshake) and packs two consecutive bytes, high byte first, into one 16-bit command word for the Segway command/auth logic. It owns the receiver's ready-clear, so no byte is consumed twice. An inter-byte timeout discards a stranded high byte so framing self-recovers. It also flags command overrun.

Parameters:
TIMEOUT_CYC, 130208, max clk cycles allowed in WAIT_LO (2.5 byte-times at 9600 baud, 50 MHz); must be >= 2
CNT_W, $clog2(TIMEOUT_CYC), timeout counter width (derived)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
rx_rdy  input  1  byte-valid from UART receiver (level, held until cleared)
rx_data  input  8  received byte, valid while rx_rdy=1
clr_rx_rdy  output  1  combinational one-cycle pulse; byte accepted this cycle
cmd  output  16  assembled command {hi,lo}
cmd_rdy  output  1  command valid, level, held until cleared
clr_cmd_rdy  input  1  consumer acknowledge
timeout  output  1  one-cycle pulse; high byte discarded
overrun  output  1  one-cycle pulse; unacknowledged command overwritten

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE, cmd=16'h0000, cmd_rdy=0, timeout=0, overrun=0, hi-byte hold=8'h00, counter=0. rst wins over every other event. Mid-byte reset drops any held high byte.
- clr_rx_rdy = rx_rdy & (state is IDLE or WAIT_LO) & ~rst. The receiver drops rdy on the next edge, so the same byte is never seen in two cycles.
- IDLE:
  - rx_rdy=1: hi <= rx_data; counter <= 0; go WAIT_LO.
- WAIT_LO:
  - rx_rdy=1: cmd <= {hi, rx_data}; cmd_rdy <= 1; go IDLE. cmd/cmd_rdy become visible the cycle after rx_rdy is sampled (latency 1).
  - rx_rdy=0 and counter == TIMEOUT_CYC-1: timeout=1 next cycle for one cycle; go IDLE; hi discarded.
  - Otherwise counter increments.
  - rx_rdy in the same cycle as expiry: the byte wins; it is used as the low byte and there is no timeout.
- cmd holds its value during assembly; only a completed pair updates it.
- cmd_rdy:
  - Set on completion.
  - Otherwise cleared by clr_cmd_rdy.
  - Completion and clr_cmd_rdy in the same cycle: cmd_rdy=1, no overrun.
- overrun: one-cycle pulse when completion occurs while cmd_rdy=1 and clr_cmd_rdy=0. The new cmd still overwrites.
- clr_cmd_rdy while cmd_rdy=0: no effect.
- Counter is CNT_W bits and never wraps; it is only live in WAIT_LO.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, WAIT_LO)
  - CLK_FREQ=50_000_000, BAUD=9600, BIT_CYC=5208, HALF_BIT_CYC=2604
  - default TIMEOUT_CYC
  - These are shared with the UART receiver/transmitter.
- One sub-module is natural: cmd_timeout_tmr (clear/enable/expire counter, parameterised by TIMEOUT_CYC). The FSM, hold register and handshake logic stay in the top.

Test Plan (bench uses TIMEOUT_CYC=100; rx_rdy model drops the cycle after clr_rx_rdy):
- Reset: rst high 2 cycles -> cmd=0000, cmd_rdy=0, clr_rx_rdy=0, timeout=0, overrun=0. Then bytes 8'hA5, 8'h3C 20 cycles apart -> clr_rx_rdy pulses once per byte; cmd=16'hA53C with cmd_rdy=1 exactly 1 cycle after the second rx_rdy sample.
- Timeout: byte 8'h12, then nothing for 100 cycles -> timeout pulses once (1 cycle), cmd_rdy stays 0. Then bytes 8'h34, 8'h56 -> cmd=16'h3456 (8'h12 discarded).
- Timeout race: low byte 8'h77 arrives exactly at counter==99 after high 8'h11 -> cmd=16'h1177, no timeout pulse.
- Overrun: complete 16'hBEEF, no ack, then complete 16'hCAFE -> overrun pulses 1 cycle, cmd=16'hCAFE, cmd_rdy=1. Repeat with clr_cmd_rdy coincident with completion -> no overrun, cmd_rdy=1.
- Ack: cmd_rdy=1, clr_cmd_rdy pulse -> cmd_rdy=0 next cycle, cmd unchanged. clr_cmd_rdy while cmd_rdy=0 -> no change.
- Reset mid-command: high 8'hFF accepted, rst pulse, then bytes 8'h01, 8'h02 -> cmd=16'h0102.
